// File: rtl/register_write_arbiter.sv
// ---------------------------------------------------------------------------
// register_write_arbiter
//
// Shares the single write port of register_file between two writeback
// sources: the ALU result path (requester 0) and the load-data path
// (requester 1). Each cycle at most one request is granted, round-robin on
// ties. The winner is registered onto the register_file write port. Writes
// that target x0 are accepted but never asserted on the port.
//
// Parameters
//   DATA_WIDTH   width of write data
//   ADDR_WIDTH   register address width
//   COUNT_WIDTH  width of the committed-write counter
//
// Ports
//   clock, reset_n           clock and asynchronous active-low reset
//   alu_valid/rd/data        requester 0 writeback request
//   alu_ready                requester 0 accepted this cycle
//   load_valid/rd/data       requester 1 writeback request
//   load_ready               requester 1 accepted this cycle
//   reg_write                write enable to register_file
//   rd_address               write address to register_file
//   write_data               write data to register_file
//   pending_valid            in-flight non-x0 write, for bypass compare
//   pending_rd               destination of the in-flight write
//   write_count              number of committed non-x0 writes (wraps)
// ---------------------------------------------------------------------------
module register_write_arbiter #(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 5,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,

    input  logic                   alu_valid,
    input  logic [ADDR_WIDTH-1:0]  alu_rd,
    input  logic [DATA_WIDTH-1:0]  alu_data,
    output logic                   alu_ready,

    input  logic                   load_valid,
    input  logic [ADDR_WIDTH-1:0]  load_rd,
    input  logic [DATA_WIDTH-1:0]  load_data,
    output logic                   load_ready,

    output logic                   reg_write,
    output logic [ADDR_WIDTH-1:0]  rd_address,
    output logic [DATA_WIDTH-1:0]  write_data,

    output logic                   pending_valid,
    output logic [ADDR_WIDTH-1:0]  pending_rd,

    output logic [COUNT_WIDTH-1:0] write_count
);

    // Identity of a requester; also the encoding of the round-robin pointer.
    typedef enum logic {
        ALU  = 1'b0,
        LOAD = 1'b1
    } requesterId;

    requesterId             lastGrant;
    logic                   grantAlu;
    logic                   grantLoad;
    logic                   transfer;
    logic [ADDR_WIDTH-1:0]  winRd;
    logic [DATA_WIDTH-1:0]  winData;
    logic                   commitWrite;

    // -----------------------------------------------------------------------
    // Grant decision.
    // A lone requester always wins; on a tie the requester that did not win
    // the most recent grant goes first. Grants are suppressed while reset is
    // held so no requester sees a handshake that the output stage would drop.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned in this block gets a default first, so
        // no path leaves it unassigned and no latch is inferred.
        grantAlu  = 1'b0;
        grantLoad = 1'b0;
        if (reset_n) begin
            if (alu_valid && load_valid) begin
                if (lastGrant == LOAD) begin
                    grantAlu = 1'b1;
                end else begin
                    grantLoad = 1'b1;
                end
            end else begin
                grantAlu  = alu_valid;
                grantLoad = load_valid;
            end
        end
    end

    assign alu_ready  = grantAlu;
    assign load_ready = grantLoad;

    // Winner mux: grants are one-hot, so selecting on grantLoad is enough.
    assign transfer    = grantAlu | grantLoad;
    assign winRd       = grantLoad ? load_rd   : alu_rd;
    assign winData     = grantLoad ? load_data : alu_data;

    // An x0 request still consumes its grant, it just never reaches the port.
    assign commitWrite = transfer && (winRd != '0);

    // -----------------------------------------------------------------------
    // Round-robin pointer. Resets to LOAD so that ALU wins the first tie.
    // Only moves on an actual transfer, x0 transfers included.
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (!reset_n) begin
            lastGrant <= LOAD;
        end else if (transfer) begin
            lastGrant <= grantLoad ? LOAD : ALU;
        end
    end

    // -----------------------------------------------------------------------
    // Output stage. register_file takes a write every cycle, so this stage
    // never stalls: the enable is a one-cycle pulse per committed request,
    // while address and data hold when idle to keep the port quiet.
    // The asynchronous clear drops an in-flight write the moment reset
    // asserts, so the register file never sees it commit.
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            reg_write  <= 1'b0;
            rd_address <= '0;
            write_data <= '0;
        end else begin
            reg_write <= commitWrite;
            if (transfer) begin
                rd_address <= winRd;
                write_data <= winData;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Committed-write counter. Counts port enables, not grants, so x0
    // requests are excluded. Wraps naturally at 2**COUNT_WIDTH.
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            write_count <= '0;
        end else if (commitWrite) begin
            write_count <= write_count + COUNT_WIDTH'(1);
        end
    end

    // The bypass view is the write port itself: whatever is on the port has
    // not yet been committed by register_file.
    assign pending_valid = reg_write;
    assign pending_rd    = rd_address;

endmodule

// File: tb/tb_register_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_register_write_arbiter
//
// Self-checking bench for register_write_arbiter. A behavioural model tracks
// who should win each cycle, what the write port should show afterwards and
// how many writes have committed. A small register file stands in for
// register_file and is compared against an architectural copy kept by the
// model. A second instance with a 2-bit counter shares the stimulus and is
// used to observe counter wrap.
// ---------------------------------------------------------------------------
module tb_register_write_arbiter;

    logic        clock;
    logic        reset_n;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [63:0] alu_data;
    logic        alu_ready;
    logic        load_valid;
    logic [4:0]  load_rd;
    logic [63:0] load_data;
    logic        load_ready;
    logic        reg_write;
    logic [4:0]  rd_address;
    logic [63:0] write_data;
    logic        pending_valid;
    logic [4:0]  pending_rd;
    logic [15:0] write_count;

    // Second instance: only its counter is of interest.
    logic        aluReadySmall;
    logic        loadReadySmall;
    logic        regWriteSmall;
    logic [4:0]  rdAddressSmall;
    logic [63:0] writeDataSmall;
    logic        pendingValidSmall;
    logic [4:0]  pendingRdSmall;
    logic [1:0]  writeCountSmall;

    register_write_arbiter #(
        .DATA_WIDTH(64), .ADDR_WIDTH(5), .COUNT_WIDTH(16)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .load_valid(load_valid), .load_rd(load_rd), .load_data(load_data), .load_ready(load_ready),
        .reg_write(reg_write), .rd_address(rd_address), .write_data(write_data),
        .pending_valid(pending_valid), .pending_rd(pending_rd),
        .write_count(write_count)
    );

    register_write_arbiter #(
        .DATA_WIDTH(64), .ADDR_WIDTH(5), .COUNT_WIDTH(2)
    ) dutSmall (
        .clock(clock), .reset_n(reset_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(aluReadySmall),
        .load_valid(load_valid), .load_rd(load_rd), .load_data(load_data), .load_ready(loadReadySmall),
        .reg_write(regWriteSmall), .rd_address(rdAddressSmall), .write_data(writeDataSmall),
        .pending_valid(pendingValidSmall), .pending_rd(pendingRdSmall),
        .write_count(writeCountSmall)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Behavioural model state.
    int          lastWinner;   // 0 = alu, 1 = load; "load" after reset so alu wins first tie
    logic        expWe;
    logic [4:0]  expRd;
    logic [63:0] expData;
    int          expCount;
    int          loadAccepts;
    bit          randomOn;

    // Register file as seen by the DUT port, and its architectural copy.
    logic [63:0] rf      [32];
    logic [63:0] rfModel [32];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] rfRead(input logic [4:0] a);
        return (a == 5'd0) ? 64'd0 : rf[a];
    endfunction

    function automatic logic [63:0] rfModelRead(input logic [4:0] a);
        return (a == 5'd0) ? 64'd0 : rfModel[a];
    endfunction

    task automatic presentAlu(input logic [4:0] rd, input logic [63:0] data);
        alu_valid = 1'b1; alu_rd = rd; alu_data = data;
    endtask

    task automatic presentLoad(input logic [4:0] rd, input logic [63:0] data);
        load_valid = 1'b1; load_rd = rd; load_data = data;
    endtask

    function automatic logic [4:0] randomRd();
        return ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    endfunction

    task automatic modelReset();
        lastWinner = 1;
        expWe      = 1'b0;
        expRd      = '0;
        expData    = '0;
        expCount   = 0;
    endtask

    // One clock cycle, entered and left on a falling edge.
    task automatic step();
        int          win;
        logic        portWe;
        logic [4:0]  portRd;
        logic [63:0] portData;
        logic [4:0]  probe;

        #1;
        portWe   = reg_write;
        portRd   = rd_address;
        portData = write_data;

        win = -1;
        if (reset_n) begin
            if (alu_valid && load_valid) win = (lastWinner == 0) ? 1 : 0;
            else if (alu_valid)          win = 0;
            else if (load_valid)         win = 1;
        end
        check("alu_ready",  {63'd0, alu_ready},  {63'd0, win == 0});
        check("load_ready", {63'd0, load_ready}, {63'd0, win == 1});

        @(posedge clock);
        if (portWe) rf[portRd] = portData;
        if (expWe)  rfModel[expRd] = expData;

        if (!reset_n) begin
            modelReset();
        end else begin
            expWe = 1'b0;
            if (win >= 0) begin
                lastWinner = win;
                expRd   = (win == 1) ? load_rd   : alu_rd;
                expData = (win == 1) ? load_data : alu_data;
                expWe   = (expRd != 5'd0);
                if (expWe) expCount++;
                if (win == 1) loadAccepts++;
            end
        end

        #1;
        check("reg_write",     {63'd0, reg_write},     {63'd0, expWe});
        check("pending_valid", {63'd0, pending_valid}, {63'd0, expWe});
        check("rd_address",    {59'd0, rd_address},    {59'd0, expRd});
        check("pending_rd",    {59'd0, pending_rd},    {59'd0, expRd});
        check("write_data",    write_data,             expData);
        check("write_count",   {48'd0, write_count},   64'(expCount % 65536));
        check("write_count_w2",{62'd0, writeCountSmall}, 64'(expCount % 4));
        probe = 5'($urandom_range(0, 31));
        check("rf_read",       rfRead(probe),          rfModelRead(probe));

        // Requesters drop valid once accepted; otherwise they hold everything.
        if (win == 0) alu_valid  = 1'b0;
        if (win == 1) load_valid = 1'b0;
        if (randomOn) begin
            if (!alu_valid  && $urandom_range(0, 3) != 0) presentAlu(randomRd(),  {$urandom, $urandom});
            if (!load_valid && $urandom_range(0, 3) != 0) presentLoad(randomRd(), {$urandom, $urandom});
        end
        @(negedge clock);
    endtask

    initial begin
        logic [4:0]  tgt;
        logic [63:0] oldVal;
        int          acceptsBefore;
        int          waited;

        for (int i = 0; i < 32; i++) begin
            rf[i]      = 64'd0;
            rfModel[i] = 64'd0;
        end
        modelReset();
        loadAccepts = 0;
        randomOn    = 1'b0;

        // Reset held with both requesters valid: nothing may be accepted.
        reset_n = 1'b0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        load_valid = 1'b0; load_rd = '0; load_data = '0;
        presentAlu(5'd3, 64'd25);
        presentLoad(5'd7, 64'd99);
        @(negedge clock);
        repeat (3) step();

        // Release: contention alternates alu, load, alu, load.
        reset_n = 1'b1;
        step();
        presentAlu(5'd4, 64'd26);
        step();
        presentLoad(5'd8, 64'd100);
        step();
        presentAlu(5'd5, 64'd27);
        step();
        check("contention_count", {48'd0, write_count}, 64'd4);
        step();

        // Single requester: write lands in the register file two edges later.
        presentAlu(5'd5, 64'd10);
        step();
        step();
        check("single_rf5", rfRead(5'd5), 64'd10);
        check("single_count", {48'd0, write_count}, 64'd6);

        // x0 request: accepted, not written, not counted, but still takes the turn.
        presentLoad(5'd0, 64'd99);
        step();
        check("x0_count", {48'd0, write_count}, 64'd6);
        presentAlu(5'd9, 64'd1);
        presentLoad(5'd10, 64'd2);
        #1;
        check("x0_next_tie_alu", {63'd0, alu_ready}, 64'd1);
        step();
        step();
        check("x0_read", rfRead(5'd0), 64'd0);
        step();

        // Stall hold: load held while alu keeps contending, accepted exactly once.
        acceptsBefore = loadAccepts;
        presentLoad(5'd11, 64'd33);
        for (int i = 0; i < 3; i++) begin
            if (!alu_valid) presentAlu(5'd12, 64'(44 + i));
            step();
        end
        check("stall_load_once", 64'(loadAccepts - acceptsBefore), 64'd1);
        step();
        step();

        // Randomised traffic.
        randomOn = 1'b1;
        repeat (3000) step();
        randomOn = 1'b0;

        // Reset mid-stream: wait for a write on the port, then pull reset.
        waited = 0;
        while (!expWe && waited < 100) begin
            if (!alu_valid) presentAlu(5'($urandom_range(1, 31)), {$urandom, $urandom});
            step();
            waited++;
        end
        check("midreset_wait", {63'd0, expWe}, 64'd1);
        tgt    = expRd;
        oldVal = rfModel[tgt];
        reset_n = 1'b0;
        #1;
        check("midreset_reg_write",     {63'd0, reg_write},     64'd0);
        check("midreset_pending_valid", {63'd0, pending_valid}, 64'd0);
        modelReset();
        alu_valid  = 1'b0;
        load_valid = 1'b0;
        @(negedge clock);
        step();
        check("midreset_target_kept", rfRead(tgt), oldVal);
        step();

        // Release as a fresh start, then five writes to wrap the 2-bit counter.
        reset_n = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            presentAlu(5'(i), 64'(i * 3));
            step();
        end
        step();
        check("wrap_count_w2", {62'd0, writeCountSmall}, 64'd1);
        check("wrap_count",    {48'd0, write_count},     64'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/register_write_arbiter.md
# register_write_arbiter

Shares the single write port of `register_file` between two writeback sources: the ALU result path (requester 0) and the load-data path (requester 1). Each source hands over `{rd, data}` with a valid/ready handshake. The arbiter grants one request per cycle round-robin and registers the winner onto the `reg_write` / `rd_address` / `write_data` port, filtering writes to x0. It also exposes the in-flight write for bypass comparison and counts committed writes.

## Interface
- `DATA_WIDTH`, 64, width of write data.
- `ADDR_WIDTH`, 5, register address width.
- `COUNT_WIDTH`, 16, width of the committed-write counter.

- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `alu_valid`  in  1  requester 0 has a writeback pending.
- `alu_rd`  in  ADDR_WIDTH  requester 0 destination register.
- `alu_data`  in  DATA_WIDTH  requester 0 write data.
- `alu_ready`  out  1  requester 0 accepted this cycle.
- `load_valid`  in  1  requester 1 has a writeback pending.
- `load_rd`  in  ADDR_WIDTH  requester 1 destination register.
- `load_data`  in  DATA_WIDTH  requester 1 write data.
- `load_ready`  out  1  requester 1 accepted this cycle.
- `reg_write`  out  1  to `register_file.reg_write`.
- `rd_address`  out  ADDR_WIDTH  to `register_file.rd_address`.
- `write_data`  out  DATA_WIDTH  to `register_file.write_data`.
- `pending_valid`  out  1  a non-x0 write is on the port this cycle (same as `reg_write`).
- `pending_rd`  out  ADDR_WIDTH  destination of the in-flight write (same as `rd_address`).
- `write_count`  out  COUNT_WIDTH  number of committed non-x0 writes.

## Operation
- **Handshake.** A transfer occurs on a rising edge where `valid && ready` for that requester.
  - A requester holds `valid`, `rd` and `data` stable until it sees `ready`.
  - `ready` is combinational from both `valid` inputs and the priority pointer.
  - At most one `ready` is high per cycle.
  - `ready` is never high without the matching `valid`.
- **Arbitration.** The output stage always drains, because `register_file` accepts a write every cycle. There is no backpressure from downstream.
  - Only one requester valid: it is granted.
  - Both valid: the requester that did not win the most recent grant is granted.
  - `last_grant` updates only on a transfer.
  - Reset value of `last_grant` is 1, so requester 0 wins the first tie.
- **Output stage.** Updated every edge.
  - On a transfer: `rd_address` and `write_data` load the winner's `rd` and `data`.
  - `reg_write` loads 1 if the winner's `rd != 0`, else 0.
  - With no transfer: `reg_write` loads 0, and `rd_address` / `write_data` hold their previous values.
- **x0 writes.** A request with `rd == 0` is accepted and consumes its grant, which updates `last_grant`. It never asserts `reg_write` and is not counted.
- **Counter.** `write_count` increments by 1 on each edge that loads `reg_write = 1`. It wraps from all-ones to 0.
- **Reset values.**
  - `reg_write`, `pending_valid`: 0.
  - `rd_address`, `pending_rd`: 0.
  - `write_data`: 0.
  - `write_count`: 0.
  - `last_grant`: 1.
  - While `reset_n` is low, `alu_ready` and `load_ready` are forced to 0.

## Timing
- **Latency.** A transfer at edge T drives the port during cycle T..T+1; `register_file` commits the write at edge T+1. Total latency is 2 edges from request acceptance to architectural update.
- **Throughput.** One write per cycle sustained.
  - Both requesters continuously valid: grants alternate 0,1,0,1…
  - Single requester continuously valid: granted every cycle.
- **Bypass.** `pending_valid` / `pending_rd` let read-side logic detect a read of a register whose write has not yet committed.
- **Reset mid-operation.** Asserting `reset_n` low clears the output stage immediately (asynchronously), so no write is issued. A request that was in flight is lost; requesters must re-present it after reset releases.
- **Release.** The first cycle after `reset_n` rises behaves as a fresh start: ties go to requester 0.

## Test plan
- **Reset.** Hold `reset_n = 0` with both valid → both `ready` = 0, `reg_write` = 0, `write_count` = 0. Release → `alu_ready` = 1 first.
- **Single requester.** `alu_valid` with rd=5, data=10 for one cycle → `alu_ready` = 1. Next cycle `reg_write` = 1, `rd_address` = 5, `write_data` = 10. A subsequent `rs1` = 5 read returns 10; `write_count` = 1.
- **Contention.** Both valid for 4 cycles (alu rd=3/25, load rd=7/99, held until accepted, then new values) → grant order alu, load, alu, load; port shows rd 3, 7, … in order; `write_count` = 4.
- **x0 filter.** `load_valid` with rd=0, data=99 → `load_ready` = 1, `reg_write` stays 0, `write_count` unchanged. The next tie goes to alu, and reading x0 returns 0.
- **Stall hold.** `load_valid` held 3 cycles while alu also valid → load accepted exactly once, with `load_rd` / `load_data` unchanged until then.
- **Reset mid-stream and wrap.**
  - Pull `reset_n` low with `reg_write` = 1 → `reg_write` drops immediately, and the target register keeps its old value.
  - Separately, with `COUNT_WIDTH` = 2, issue 5 writes → `write_count` reads 1.
